// File: rtl/rop3_pkg.sv
// Shared types and constants for the ROP3 blit controller.
package rop3_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [7:0] ROP_BLACK     = 8'h00;
    localparam logic [7:0] ROP_SRCCOPY   = 8'hCC;
    localparam logic [7:0] ROP_PATCOPY   = 8'hF0;
    localparam logic [7:0] ROP_SRCINVERT = 8'h66;
    localparam logic [7:0] ROP_WHITE     = 8'hFF;

    // Register stages inside rop3_smart (input register, output register).
    localparam int unsigned DP_LATENCY = 2;

    // One result bit: the mode byte is a truth table indexed by {P,S,D}.
    function automatic logic rop3_bit(input logic [7:0] mode, input logic p,
                                      input logic s, input logic d);
        return mode[{p, s, d}];
    endfunction

endpackage

// File: rtl/rop3_res_fifo.sv
// Show-ahead result FIFO with occupancy count.
module rop3_res_fifo #(
    parameter int unsigned W     = 5,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_c, do_push_c, do_pop_c;

    // Pointer and count update; a push into a full FIFO is legal only alongside a pop.
    always_comb begin
        full_c    = (count_q == CNT_W'(DEPTH));
        do_pop_c  = pop && (count_q != '0);
        do_push_c = push && (!full_c || do_pop_c);
        wr_ptr_d  = do_push_c ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = do_pop_c  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d   = count_q + CNT_W'(do_push_c) - CNT_W'(do_pop_c);
    end

    // Storage and pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push_c) begin
                mem_q[wr_ptr_q] <= wdata;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/rop3_smart.sv
// Free-running ROP3 datapath: operand register, then result register.
module rop3_smart
    import rop3_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   mode,
    input  logic [N-1:0] p,
    input  logic [N-1:0] s,
    input  logic [N-1:0] d,
    output logic [N-1:0] result
);

    logic [7:0]   mode_q;
    logic [N-1:0] p_q, s_q, d_q;
    logic [N-1:0] res_q, res_d;

    // Bitwise truth-table lookup on the registered operands.
    always_comb begin
        res_d = '0;
        for (int i = 0; i < int'(N); i++) begin
            res_d[i] = rop3_bit(mode_q, p_q[i], s_q[i], d_q[i]);
        end
    end

    // Two register stages, no stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= '0;
            p_q    <= '0;
            s_q    <= '0;
            d_q    <= '0;
            res_q  <= '0;
        end else begin
            mode_q <= mode;
            p_q    <= p;
            s_q    <= s;
            d_q    <= d;
            res_q  <= res_d;
        end
    end

    assign result = res_q;

endmodule

// File: rtl/rop3_blit_ctrl.sv
// Command sequencer streaming operand triples through rop3_smart into a credit-guarded FIFO.
module rop3_blit_ctrl
    import rop3_pkg::*;
#(
    parameter int unsigned N          = 4,
    parameter int unsigned LEN_W      = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [7:0]       cmd_mode,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic [N-1:0]     pix_p,
    input  logic [N-1:0]     pix_s,
    input  logic [N-1:0]     pix_d,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [N-1:0]     res_data,
    output logic             res_last,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned OCC_W = CNT_W + 1;

    state_e                state_q, state_d;
    logic [7:0]            mode_q, mode_d;
    logic [LEN_W-1:0]      remain_q, remain_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  op_vld_q, op_vld_d;
    logic                  op_last_q, op_last_d;
    logic [N-1:0]          op_p_q, op_p_d, op_s_q, op_s_d, op_d_q, op_d_d;
    logic [DP_LATENCY-1:0] vld_q, vld_d;
    logic [DP_LATENCY-1:0] last_q, last_d;

    logic [N-1:0]          dp_res;
    logic [N:0]            fifo_rdata;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_pop_c;
    logic [1:0]            inflight_c;
    logic [OCC_W-1:0]      occ_c;
    logic                  cmd_fire_c, pix_fire_c;

    // Handshakes and credit check; a same-cycle pop frees a slot for the next accept.
    always_comb begin
        fifo_pop_c = !fifo_empty && res_ready;
        inflight_c = 2'(op_vld_q) + 2'(vld_q[0]) + 2'(vld_q[1]);
        occ_c      = OCC_W'(fifo_count) + OCC_W'(inflight_c) - OCC_W'(fifo_pop_c);
        pix_ready  = (state_q == ST_RUN) && (remain_q != '0) &&
                     (occ_c < OCC_W'(FIFO_DEPTH));
        cmd_fire_c = cmd_valid && cmd_ready_q;
        pix_fire_c = pix_valid && pix_ready;
    end

    // Next-state, command latch and operand/valid pipe.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        remain_d = remain_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_fire_c) begin
                    mode_d   = cmd_mode;
                    remain_d = cmd_len;
                    state_d  = (cmd_len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (pix_fire_c) begin
                    if (remain_q != '0) begin
                        remain_d = remain_q - LEN_W'(1);
                    end
                    if (remain_q == LEN_W'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if ((inflight_c == 2'd0) && fifo_empty) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);

        op_vld_d  = pix_fire_c;
        op_last_d = pix_fire_c && (remain_q == LEN_W'(1));
        op_p_d    = pix_fire_c ? pix_p : op_p_q;
        op_s_d    = pix_fire_c ? pix_s : op_s_q;
        op_d_d    = pix_fire_c ? pix_d : op_d_q;
        vld_d     = {vld_q[0], op_vld_q};
        last_d    = {last_q[0], op_last_q};
    end

    // All controller state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mode_q      <= '0;
            remain_q    <= '0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            op_vld_q    <= 1'b0;
            op_last_q   <= 1'b0;
            op_p_q      <= '0;
            op_s_q      <= '0;
            op_d_q      <= '0;
            vld_q       <= '0;
            last_q      <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            remain_q    <= remain_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            op_vld_q    <= op_vld_d;
            op_last_q   <= op_last_d;
            op_p_q      <= op_p_d;
            op_s_q      <= op_s_d;
            op_d_q      <= op_d_d;
            vld_q       <= vld_d;
            last_q      <= last_d;
        end
    end

    rop3_smart #(.N(N)) u_dp (
        .clk    (clk),
        .rst    (rst),
        .mode   (mode_q),
        .p      (op_p_q),
        .s      (op_s_q),
        .d      (op_d_q),
        .result (dp_res)
    );

    rop3_res_fifo #(.W(N + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (vld_q[1]),
        .wdata ({dp_res, last_q[1]}),
        .pop   (fifo_pop_c),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign res_valid = !fifo_empty;
    assign res_data  = fifo_rdata[N:1];
    assign res_last  = fifo_rdata[0];

endmodule

// File: tb/tb_rop3_blit_ctrl.sv
// Self-checking bench for rop3_blit_ctrl: vector table, corner sequences, random commands.
module tb_rop3_blit_ctrl;
    import rop3_pkg::*;

    localparam int unsigned N     = 4;
    localparam int unsigned LEN_W = 8;
    localparam int unsigned FD    = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [7:0]       cmd_mode = '0;
    logic [LEN_W-1:0] cmd_len = '0;
    logic             pix_valid = 1'b0;
    logic             pix_ready;
    logic [N-1:0]     pix_p = '0, pix_s = '0, pix_d = '0;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [N-1:0]     res_data;
    logic             res_last;
    logic             busy;
    logic             done;

    rop3_blit_ctrl #(.N(N), .LEN_W(LEN_W), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode), .cmd_len(cmd_len),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_p(pix_p), .pix_s(pix_s), .pix_d(pix_d),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: sum of the minterms selected by the mode byte.
    function automatic logic [3:0] rop_model(input logic [7:0] m, input logic [3:0] p,
                                             input logic [3:0] s, input logic [3:0] d);
        logic [3:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            if (m[k]) r |= (k[2] ? p : ~p) & (k[1] ? s : ~s) & (k[0] ? d : ~d);
        end
        return r;
    endfunction

    // Observation: handshakes recorded with the edge index at which they complete.
    int         cyc = 0;
    int         cmd_cnt = 0, cmd_edge = 0;
    int         done_cnt = 0, done_cyc = 0, rdy_rise_cyc = 0;
    int         pr_seen = 0, rv_seen = 0, overlap = 0;
    bit         rdy_prev = 1'b0;
    int         acc_edge[$];
    int         got_edge[$];
    logic [3:0] got_data[$];
    logic       got_last[$];
    logic [3:0] tp[$], ts[$], td[$];
    int         rr_mode = 1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (cmd_valid && cmd_ready) begin cmd_cnt++; cmd_edge = cyc + 1; end
            if (pix_valid && pix_ready) acc_edge.push_back(cyc + 1);
            if (res_valid && res_ready) begin
                got_data.push_back(res_data);
                got_last.push_back(res_last);
                got_edge.push_back(cyc + 1);
            end
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (cmd_ready && !rdy_prev) rdy_rise_cyc = cyc;
            rdy_prev = cmd_ready;
            if (pix_ready) pr_seen++;
            if (res_valid) rv_seen++;
            if (done && cmd_ready) overlap++;
        end
    end

    always @(posedge clk) begin
        #1;
        case (rr_mode)
            0:       res_ready = 1'b0;
            1:       res_ready = 1'b1;
            default: res_ready = ($urandom_range(0, 2) != 0);
        endcase
    end

    task automatic send_cmd(input logic [7:0] m, input int len);
        int n0, t;
        n0 = cmd_cnt; t = 0;
        cmd_mode = m; cmd_len = 8'(len); cmd_valid = 1'b1;
        do begin @(posedge clk); #1; t++; end while (cmd_cnt == n0 && t < 100);
        cmd_valid = 1'b0;
        chk("cmd_accepted", 32'(cmd_cnt - n0), 32'd1);
    endtask

    task automatic feed(input int len, input bit gaps);
        int k, t, base;
        base = acc_edge.size(); k = 0; t = 0;
        while (k < len && t < 400) begin
            pix_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            pix_p = tp[k]; pix_s = ts[k]; pix_d = td[k];
            @(posedge clk); #1; t++;
            k = acc_edge.size() - base;
        end
        pix_valid = 1'b0;
        chk("pix_accepted", 32'(k), 32'(len));
    endtask

    task automatic wait_done(input int d0);
        int t;
        t = 0;
        while (done_cnt == d0 && t < 400) begin @(posedge clk); #1; t++; end
        chk("done_seen", 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic run_cmd(input logic [7:0] m, input int len, input bit gaps);
        int d0;
        d0 = done_cnt;
        acc_edge.delete(); got_edge.delete(); got_data.delete(); got_last.delete();
        pr_seen = 0; rv_seen = 0;
        send_cmd(m, len);
        feed(len, gaps);
        wait_done(d0);
        chk($sformatf("res_count m=%0h", m), 32'(got_data.size()), 32'(len));
        for (int k = 0; k < len && k < got_data.size(); k++) begin
            chk($sformatf("res_data m=%0h k=%0d", m, k), 32'(got_data[k]),
                32'(rop_model(m, tp[k], ts[k], td[k])));
            chk($sformatf("res_last m=%0h k=%0d", m, k), 32'(got_last[k]), 32'(k == len - 1));
        end
    endtask

    task automatic fill_rand(input int len);
        tp.delete(); ts.delete(); td.delete();
        for (int k = 0; k < len; k++) begin
            tp.push_back(4'($urandom)); ts.push_back(4'($urandom)); td.push_back(4'($urandom));
        end
    endtask

    typedef struct {
        logic [7:0] mode;
        logic [3:0] p, s, d, exp;
    } vec_t;

    vec_t vt[10];

    initial begin
        int dc, d0;

        vt[0] = '{8'hCC, 4'h3, 4'hA, 4'h5, 4'hA};
        vt[1] = '{8'hF0, 4'h3, 4'hA, 4'h5, 4'h3};
        vt[2] = '{8'h66, 4'h3, 4'hA, 4'h5, 4'hF};
        vt[3] = '{8'h66, 4'h0, 4'hA, 4'hF, 4'h5};
        vt[4] = '{8'h66, 4'h7, 4'hA, 4'hA, 4'h0};
        vt[5] = '{8'h00, 4'hF, 4'hF, 4'hF, 4'h0};
        vt[6] = '{8'hFF, 4'h0, 4'h0, 4'h0, 4'hF};
        vt[7] = '{8'h88, 4'h1, 4'hC, 4'hA, 4'h8};
        vt[8] = '{8'h5A, 4'hC, 4'h3, 4'hA, 4'h6};
        vt[9] = '{8'h33, 4'h9, 4'hA, 4'h2, 4'h5};

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        chk("rst cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst pix_ready", 32'(pix_ready), 32'd0);
        chk("rst res_valid", 32'(res_valid), 32'd0);
        chk("rst res_data", 32'(res_data), 32'd0);
        chk("rst res_last", 32'(res_last), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post-rst cmd_ready", 32'(cmd_ready), 32'd1);
        chk("post-rst busy", 32'(busy), 32'd0);

        // Single-word vector table.
        rr_mode = 1;
        for (int i = 0; i < 10; i++) begin
            tp.delete(); ts.delete(); td.delete();
            tp.push_back(vt[i].p); ts.push_back(vt[i].s); td.push_back(vt[i].d);
            run_cmd(vt[i].mode, 1, 1'b0);
            chk($sformatf("vec %0d", i), 32'(got_data.size() > 0 ? got_data[0] : 4'hx), 32'(vt[i].exp));
        end

        // SRCCOPY len 4: latency, throughput, last, done and ready timing.
        fill_rand(4);
        for (int k = 0; k < 4; k++) ts[k] = 4'(k + 1);
        run_cmd(ROP_SRCCOPY, 4, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        if (got_edge.size() == 4 && acc_edge.size() == 4) begin
            chk("first latency", 32'(got_edge[0] - acc_edge[0]), 32'd4);
            chk("accept spacing", 32'(acc_edge[3] - acc_edge[0]), 32'd3);
            chk("result spacing", 32'(got_edge[3] - got_edge[0]), 32'd3);
            chk("done after last pop", 32'(done_cyc), 32'(got_edge[3] + 1));
        end
        chk("ready after done", 32'(rdy_rise_cyc), 32'(done_cyc + 1));

        // SRCINVERT len 3.
        fill_rand(3);
        ts[0] = 4'hA; ts[1] = 4'hA; ts[2] = 4'hA;
        td[0] = 4'h5; td[1] = 4'hF; td[2] = 4'hA;
        run_cmd(ROP_SRCINVERT, 3, 1'b0);
        if (got_data.size() == 3) begin
            chk("xor w0", 32'(got_data[0]), 32'hF);
            chk("xor w1", 32'(got_data[1]), 32'h5);
            chk("xor w2", 32'(got_data[2]), 32'h0);
        end

        // PATCOPY len 8 with the consumer stalled: credit limit, then release.
        rr_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        fill_rand(8);
        for (int k = 0; k < 8; k++) tp[k] = 4'(k + 1);
        fork
            run_cmd(ROP_PATCOPY, 8, 1'b0);
            begin
                repeat (12) @(posedge clk);
                #1;
                chk("credit accepts", 32'(acc_edge.size()), 32'd4);
                chk("credit pix_ready", 32'(pix_ready), 32'd0);
                chk("credit res_valid", 32'(res_valid), 32'd1);
                rr_mode = 1;
            end
        join

        // Zero-length command.
        fill_rand(0);
        run_cmd(ROP_WHITE, 0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("len0 pix_ready", 32'(pr_seen), 32'd0);
        chk("len0 res_valid", 32'(rv_seen), 32'd0);
        chk("len0 done timing", 32'(done_cyc), 32'(cmd_edge));
        chk("len0 ready after done", 32'(rdy_rise_cyc), 32'(done_cyc + 1));

        // Reset mid-command.
        fill_rand(6);
        d0 = done_cnt;
        acc_edge.delete();
        send_cmd(ROP_BLACK, 6);
        feed(2, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst cmd_ready", 32'(cmd_ready), 32'd0);
        chk("midrst pix_ready", 32'(pix_ready), 32'd0);
        chk("midrst res_valid", 32'(res_valid), 32'd0);
        chk("midrst res_data", 32'(res_data), 32'd0);
        chk("midrst res_last", 32'(res_last), 32'd0);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst done", 32'(done), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst no done", 32'(done_cnt - d0), 32'd0);
        chk("midrst cmd_ready after", 32'(cmd_ready), 32'd1);
        tp.delete(); ts.delete(); td.delete();
        tp.push_back(4'h5); ts.push_back(4'h9); td.push_back(4'h3);
        run_cmd(ROP_SRCCOPY, 1, 1'b0);
        chk("after rst word", 32'(got_data.size() > 0 ? got_data[0] : 4'hx), 32'h9);

        // Back-to-back commands with different modes.
        overlap = 0;
        fill_rand(3);
        run_cmd(ROP_BLACK, 3, 1'b0);
        dc = done_cyc;
        fill_rand(3);
        run_cmd(ROP_WHITE, 3, 1'b0);
        chk("b2b accept edge", 32'(cmd_edge), 32'(dc + 2));
        chk("b2b done/ready overlap", 32'(overlap), 32'd0);

        // Randomized commands with random gaps and backpressure.
        rr_mode = 2;
        for (int i = 0; i < 25; i++) begin
            int len;
            logic [7:0] m;
            len = int'($urandom_range(0, 10));
            m = 8'($urandom);
            fill_rand(len);
            run_cmd(m, len, 1'b1);
        end
        chk("total overlap", 32'(overlap), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
